// File: rtl/aurora_pkg.sv
// Shared types and defaults for the Aurora CC scheduler.
// AURORA_CC_SCHEDULER_CC_EN selects whether the CC state exists.
`ifndef AURORA_PKG_DEFAULTS
`define AURORA_PKG_DEFAULTS
`define CC_PERIOD_DEFAULT 5000
`define CC_LEN_DEFAULT 6
`endif

package aurora_pkg;

  typedef enum logic [1:0] {
    SEL_INIT = 2'd0,
    SEL_IDLE = 2'd1,
    SEL_DATA = 2'd2,
    SEL_CC   = 2'd3
  } sel_e;

`ifdef AURORA_CC_SCHEDULER_CC_EN
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_CC   = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
`endif

  // Counter width for a count range of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aurora_cc_scheduler_if.sv
// Handshake and lane-select bundle between the scheduler and its neighbours.
// master: the scheduler; slave: initialiser, data controller and lane mux.
interface aurora_cc_scheduler_if;
  import aurora_pkg::*;

  logic channel_up;
  logic data_valid;
  logic cc_req;
  logic data_ready;
  sel_e sel;
  logic cc_active;
  logic cc_done;

  modport master (
    input  channel_up,
    input  data_valid,
    input  cc_req,
    output data_ready,
    output sel,
    output cc_active,
    output cc_done
  );

  modport slave (
    output channel_up,
    output data_valid,
    output cc_req,
    input  data_ready,
    input  sel,
    input  cc_active,
    input  cc_done
  );

endinterface

// File: rtl/aurora_cc_scheduler_timer.sv
// Period counter and pending-request flag that decide when a CC is due.
// Only built when AURORA_CC_SCHEDULER_CC_EN is defined.
module cc_period_timer
  import aurora_pkg::*;
#(
  parameter int unsigned CC_PERIOD = `CC_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  input  logic cc_req,
  output logic cc_due
);

  localparam int unsigned    PER_W    = cnt_width(CC_PERIOD);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CC_PERIOD - 1);

  logic [PER_W-1:0] count_q;
  logic             pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (clear) begin
        count_q <= '0;
      end else if (count_en) begin
        count_q <= count_q + PER_W'(1);
      end
      if (clear) begin
        pending_q <= 1'b0;
      end else if (cc_req) begin
        pending_q <= 1'b1;
      end
    end
  end

  // A live request counts as due so a request seen in RUN switches at the same edge.
  assign cc_due = (count_q == PER_LAST) || pending_q || cc_req;

endmodule

// File: rtl/aurora_cc_scheduler.sv
// Lane source scheduler: INIT/RUN/CC sequencing with periodic and requested CC.
// CC insertion is only built when AURORA_CC_SCHEDULER_CC_EN is defined.
module aurora_cc_scheduler
  import aurora_pkg::*;
#(
  parameter int unsigned CC_PERIOD = `CC_PERIOD_DEFAULT,
  parameter int unsigned CC_LEN    = `CC_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aurora_cc_scheduler_if.master bus
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef AURORA_CC_SCHEDULER_CC_EN

  localparam int unsigned      LEN_W    = cnt_width(CC_LEN);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(CC_LEN - 1);

  logic [LEN_W-1:0] len_q;
  logic             len_last;
  logic             cc_due;
  logic             req_ok;
  logic             enter_cc;
  logic             period_clear;
  logic             cc_done_q;

  assign len_last     = (len_q == LEN_LAST);
  assign req_ok       = bus.cc_req && (state_q != ST_CC);
  assign enter_cc     = (state_q == ST_RUN) && (state_d == ST_CC);
  // Dropping channel_up also discards any pending request.
  assign period_clear = !bus.channel_up || enter_cc;

  cc_period_timer #(
    .CC_PERIOD (CC_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (state_q == ST_RUN),
    .clear    (period_clear),
    .cc_req   (req_ok),
    .cc_due   (cc_due)
  );

  always_comb begin
    state_d = state_q;
    if (!bus.channel_up) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: state_d = ST_RUN;
        ST_RUN:  if (cc_due) state_d = ST_CC;
        ST_CC:   if (len_last) state_d = ST_RUN;
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      cc_done_q <= 1'b0;
    end else begin
      cc_done_q <= bus.channel_up && (state_q == ST_CC) && len_last;
      if (bus.channel_up && (state_q == ST_CC) && !len_last) begin
        len_q <= len_q + LEN_W'(1);
      end else begin
        len_q <= '0;
      end
    end
  end

  always_comb begin
    bus.data_ready = (state_q == ST_RUN);
    bus.cc_active  = (state_q == ST_CC);
    bus.cc_done    = cc_done_q;
    case (state_q)
      ST_RUN:  bus.sel = bus.data_valid ? SEL_DATA : SEL_IDLE;
      ST_CC:   bus.sel = SEL_CC;
      default: bus.sel = SEL_INIT;
    endcase
  end

`else

  logic unused_cfg;
  assign unused_cfg = ^{bus.cc_req, 32'(CC_PERIOD), 32'(CC_LEN)};

  always_comb begin
    state_d = state_q;
    if (!bus.channel_up) begin
      state_d = ST_INIT;
    end else if (state_q == ST_INIT) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    bus.data_ready = (state_q == ST_RUN);
    bus.cc_active  = 1'b0;
    bus.cc_done    = 1'b0;
    if (state_q == ST_RUN) begin
      bus.sel = bus.data_valid ? SEL_DATA : SEL_IDLE;
    end else begin
      bus.sel = SEL_INIT;
    end
  end

`endif

endmodule

// File: tb/tb_aurora_cc_scheduler.sv
// Self-checking bench for aurora_cc_scheduler with CC_PERIOD=8, CC_LEN=3;
// follows AURORA_CC_SCHEDULER_CC_EN for which behaviour is expected.
module tb_aurora_cc_scheduler;
  import aurora_pkg::*;

  localparam int CC_PERIOD = 8;
  localparam int CC_LEN    = 3;
`ifdef AURORA_CC_SCHEDULER_CC_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   run_cmp = 1'b0;

  aurora_cc_scheduler_if bus ();

  aurora_cc_scheduler #(
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: mode plus counts of completed RUN / CC cycles.
  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_CC   = 2;

  typedef struct {
    int mode;
    int run_cnt;
    int cc_cnt;
    bit pend;
    bit done;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.mode = M_INIT; r.run_cnt = 0; r.cc_cnt = 0; r.pend = 1'b0; r.done = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input bit up, input bit req);
    model_t n;
    n = c;
    n.done = 1'b0;
    if (!up) return model_reset();
    case (c.mode)
      M_INIT: begin
        n.mode = M_RUN;
        n.run_cnt = 0;
        if (CC_EN && req) n.pend = 1'b1;
      end
      M_RUN: begin
        n.run_cnt = c.run_cnt + 1;
        if (CC_EN && req) n.pend = 1'b1;
        if (CC_EN && (n.run_cnt == CC_PERIOD || n.pend)) begin
          n.mode = M_CC; n.run_cnt = 0; n.cc_cnt = 0; n.pend = 1'b0;
        end
      end
      default: begin
        n.cc_cnt = c.cc_cnt + 1;
        if (n.cc_cnt == CC_LEN) begin
          n.mode = M_RUN;
          n.done = 1'b1;
        end
      end
    endcase
    return n;
  endfunction

  model_t m = model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, bus.channel_up, bus.cc_req);
  end

  function automatic sel_e exp_sel(input model_t s, input logic dv);
    case (s.mode)
      M_RUN:   return dv ? SEL_DATA : SEL_IDLE;
      M_CC:    return SEL_CC;
      default: return SEL_INIT;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (run_cmp) begin
        check("sel", bus.sel, exp_sel(m, bus.data_valid));
        check("data_ready", bus.data_ready, 32'(m.mode == M_RUN));
        check("cc_active", bus.cc_active, 32'(m.mode == M_CC));
        check("cc_done", bus.cc_done, 32'(m.done));
      end
    end
  end

  task automatic restart();
    @(negedge clk); bus.channel_up = 1'b0;
    repeat (2) @(negedge clk);
    bus.channel_up = 1'b1;
  endtask

  initial begin
    int ready_cnt;
    int cc_sel_cnt;
    bus.channel_up = 1'b0;
    bus.data_valid = 1'b0;
    bus.cc_req     = 1'b0;

    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    run_cmp = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("init_sel", bus.sel, SEL_INIT);
    check("init_ready", bus.data_ready, 0);
    check("init_cc_active", bus.cc_active, 0);

`ifdef AURORA_CC_SCHEDULER_CC_EN
    // Steady-state: 8 data cycles, 3 CC cycles, then cc_done.
    @(negedge clk); bus.channel_up = 1'b1; bus.data_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check("period_sel_data", bus.sel, SEL_DATA);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("cc_stall", bus.data_ready, 0);
      check("cc_sel", bus.sel, SEL_CC);
    end
    @(negedge clk); #1;
    check("cc_done_pulse", bus.cc_done, 1);
    check("after_cc_ready", bus.data_ready, 1);
    @(negedge clk); #1;
    check("cc_done_single", bus.cc_done, 0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.data_valid = (i % 3 != 0);
    end

    // Request two cycles into RUN; request during CC is ignored.
    bus.data_valid = 1'b1;
    restart();
    @(negedge clk);
    @(negedge clk); bus.cc_req = 1'b1;
    @(negedge clk); bus.cc_req = 1'b0; #1;
    check("req_cc_next", bus.cc_active, 1);
    @(negedge clk); bus.cc_req = 1'b1;
    @(negedge clk); bus.cc_req = 1'b0;
    @(negedge clk); #1;
    check("req_cc_done", bus.cc_done, 1);
    check("req_in_cc_ignored", bus.data_ready, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      check("req_then_run", bus.data_ready, 1);
    end
    @(negedge clk); #1;
    check("req_then_periodic", bus.cc_active, 1);

    // Request coinciding with period expiry gives one CC.
    restart();
    repeat (8) @(negedge clk);
    bus.cc_req = 1'b1;
    @(negedge clk); bus.cc_req = 1'b0; #1;
    check("coincide_cc", bus.cc_active, 1);
    repeat (2) @(negedge clk);
    @(negedge clk); #1;
    check("coincide_done", bus.cc_done, 1);
    @(negedge clk); #1;
    check("coincide_single", bus.data_ready, 1);

    // channel_up drops in the second CC cycle.
    restart();
    repeat (8) @(negedge clk);
    @(negedge clk); #1;
    check("abort_cc1", bus.cc_active, 1);
    @(negedge clk); bus.channel_up = 1'b0;
    @(negedge clk); #1;
    check("abort_init", bus.sel, SEL_INIT);
    check("abort_no_done", bus.cc_done, 0);
    @(negedge clk); #1;
    check("abort_no_done2", bus.cc_done, 0);
    @(negedge clk); bus.channel_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check("reup_run", bus.data_ready, 1);
    end
    @(negedge clk); #1;
    check("reup_cc", bus.cc_active, 1);

    // Request captured in INIT is served after one RUN cycle.
    @(negedge clk); bus.channel_up = 1'b0;
    repeat (2) @(negedge clk);
    bus.channel_up = 1'b1; bus.cc_req = 1'b1;
    @(negedge clk); bus.cc_req = 1'b0; #1;
    check("init_req_run", bus.data_ready, 1);
    @(negedge clk); #1;
    check("init_req_cc", bus.cc_active, 1);
    repeat (2) @(negedge clk);
`else
    @(negedge clk); bus.channel_up = 1'b1;
    ready_cnt  = 0;
    cc_sel_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.data_valid = (i % 4 != 3);
      bus.cc_req     = (i % 7 == 2);
      #1;
      if (bus.data_ready === 1'b1) ready_cnt++;
      if (bus.sel == SEL_CC) cc_sel_cnt++;
    end
    bus.cc_req = 1'b0;
    check("nocc_ready_cycles", 32'(ready_cnt), 100);
    check("nocc_sel_cc_cycles", 32'(cc_sel_cnt), 0);
    @(negedge clk); bus.channel_up = 1'b0;
    @(negedge clk); #1;
    check("nocc_drop_init", bus.sel, SEL_INIT);
    @(negedge clk); bus.channel_up = 1'b1;
    @(negedge clk); #1;
    check("nocc_reup_ready", bus.data_ready, 1);
    repeat (4) @(negedge clk);
`endif

    // Asynchronous reset between clock edges.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_sel", bus.sel, SEL_INIT);
    check("async_ready", bus.data_ready, 0);
    check("async_cc_active", bus.cc_active, 0);
    check("async_cc_done", bus.cc_done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (14) @(negedge clk);

    #2;
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aurora_cc_scheduler.md
# aurora_cc_scheduler

Sequences the shared lane datapath of the Aurora transmitter after channel initialisation. It chooses, every cycle, whether the lane controller carries initialisation ordered sets, idles, user data or clock-compensation (CC) sequences. It inserts CC sequences periodically and on request, and stalls the data controller while CC is on the lanes. It sits between the channel initialiser and data controller on one side and the ordered-set/data mux in front of the lane controller on the other.

## Interface
Parameters:
- CC_PERIOD, default 5000: number of RUN cycles between CC insertions; legal range ≥ 2.
- CC_LEN, default 6: number of cycles in one CC sequence; legal range ≥ 1.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- channel_up  in  1  channel initialiser has finished; level signal.
- data_valid  in  1  data controller holds a word to send.
- cc_req  in  1  single-cycle request for an extra CC sequence (management or receiver side).
- data_ready  out  1  data controller may advance; a transfer occurs when data_valid && data_ready.
- sel  out  sel_e (2)  lane source select: SEL_INIT, SEL_IDLE, SEL_DATA or SEL_CC.
- cc_active  out  1  CC sequence is on the lanes.
- cc_done  out  1  one-cycle pulse on the first RUN cycle after a CC sequence.

## Operation
- States: INIT, RUN, CC. The state is registered.
- Reset values:
  - state = INIT.
  - Both counters = 0.
  - cc_pending = 0.
  - cc_done = 0.
  - Outputs follow from these: data_ready = 0, sel = SEL_INIT, cc_active = 0.
- Outputs decoded from the state register:
  - data_ready = (state == RUN).
  - cc_active = (state == CC).
  - sel = SEL_INIT in INIT; SEL_CC in CC; in RUN, SEL_DATA if data_valid, otherwise SEL_IDLE.
- INIT → RUN when channel_up = 1. The period counter is cleared on entry to RUN.
- RUN:
  - The period counter increments every RUN cycle.
  - RUN → CC when the period counter == CC_PERIOD-1, or when cc_pending = 1.
  - The period counter clears on entry to CC.
- CC:
  - The length counter counts 0 … CC_LEN-1.
  - At CC_LEN-1: CC → RUN, the length counter clears, and cc_done pulses on the next cycle.
- cc_pending:
  - Set by cc_req in INIT or RUN.
  - Cleared on entry to CC.
  - cc_req while in CC is ignored.
  - If cc_req and period expiry happen in the same cycle, exactly one CC is inserted.
- channel_up = 0 in any state → INIT on the next edge.
  - Both counters and cc_pending are cleared.
  - A CC sequence in progress is aborted.
  - cc_done does not pulse.
- Counter widths: $clog2(CC_PERIOD) and $clog2(CC_LEN), minimum 1 bit each. Wrap-around is never reached; counters clear as defined above.

## Timing
- channel_up sampled high at edge n → RUN from cycle n+1, so data_ready = 1 in cycle n+1.
- Steady state: exactly CC_PERIOD RUN cycles, then exactly CC_LEN CC cycles, repeating.
- cc_req sampled in RUN at edge n → CC from cycle n+1, so data_ready falls in cycle n+1.
- A data word presented during CC is held by the data controller. It is accepted in the first RUN cycle after CC; nothing is dropped or duplicated.
- Asynchronous reset mid-operation forces the reset values immediately, regardless of clk.

## Configuration
- Macro AURORA_CC_SCHEDULER_CC_EN.
- Defined: full behaviour as described above.
- Undefined:
  - The CC state, counters and cc_pending are not built.
  - cc_req is ignored.
  - cc_active and cc_done are tied to 0.
  - sel never takes SEL_CC.
  - States are INIT and RUN only; data_ready = (state == RUN).

## Structure
- Shared in aurora_pkg:
  - the sel_e enum (SEL_INIT, SEL_IDLE, SEL_DATA, SEL_CC);
  - `CC_PERIOD_DEFAULT and `CC_LEN_DEFAULT.
- One sub-module: cc_period_timer.
  - Contains the period counter and the cc_pending flag.
  - Inputs: count enable, clear, cc_req.
  - Output: cc_due.
- The FSM and the length counter stay in the top module.

## Test plan
Parameters for all scenarios unless stated: CC_PERIOD = 8, CC_LEN = 3.
- Reset, channel_up = 0 for 10 cycles → sel = SEL_INIT, data_ready = 0 and cc_active = 0 throughout.
- channel_up rises, data_valid = 1 constant → 8 cycles with sel = SEL_DATA, then 3 cycles with sel = SEL_CC and data_ready = 0, then a cc_done pulse; pattern repeats.
- cc_req 2 cycles into RUN → CC starts the next cycle; the next periodic CC follows 8 RUN cycles later. cc_req during CC → no extra CC.
- cc_req in the same cycle the period counter = 7 → exactly one 3-cycle CC.
- channel_up drops in the 2nd CC cycle → INIT next edge, no cc_done. On re-assert, the first CC comes after 8 RUN cycles.
- With AURORA_CC_SCHEDULER_CC_EN undefined, 100 RUN cycles with cc_req pulses → sel never SEL_CC, data_ready = 1 throughout.
